// File: rtl/shift_operand_stage_if.sv
// shift_operand_stage_if: operand beat in, shifter operands out.
// Optional SHIFT_CARRY_EN adds carry_in and shifter_carry.
//
// Ports
//   flush                                 sync kill of held beats
//   in_valid/in_ready                     upstream handshake
//   op2_imm, imm8, rot4                   rotated immediate
//   sh_reg, shamt_imm, sh_type_in         shift control
//   rm_data, rs_data                      register operands
//   out_valid/out_ready                   downstream handshake
//   shift_amount, shift_type, rd2         shifter operands
//   carry_in, shifter_carry               only with SHIFT_CARRY_EN
//
// Modports
//   slave  : the stage itself
//   master : the environment that drives it
interface shift_operand_stage_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              op2_imm;
    logic [7:0]        imm8;
    logic [3:0]        rot4;
    logic              sh_reg;
    logic [4:0]        shamt_imm;
    logic [1:0]        sh_type_in;
    logic [DATA_W-1:0] rm_data;
    logic [DATA_W-1:0] rs_data;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        shift_amount;
    logic [1:0]        shift_type;
    logic [DATA_W-1:0] rd2;
`ifdef SHIFT_CARRY_EN
    logic              carry_in;
    logic              shifter_carry;
`endif

    modport slave (
        input  flush,
        input  in_valid,
        input  op2_imm,
        input  imm8,
        input  rot4,
        input  sh_reg,
        input  shamt_imm,
        input  sh_type_in,
        input  rm_data,
        input  rs_data,
        input  out_ready,
`ifdef SHIFT_CARRY_EN
        input  carry_in,
        output shifter_carry,
`endif
        output in_ready,
        output out_valid,
        output shift_amount,
        output shift_type,
        output rd2
    );

    modport master (
        output flush,
        output in_valid,
        output op2_imm,
        output imm8,
        output rot4,
        output sh_reg,
        output shamt_imm,
        output sh_type_in,
        output rm_data,
        output rs_data,
        output out_ready,
`ifdef SHIFT_CARRY_EN
        output carry_in,
        input  shifter_carry,
`endif
        input  in_ready,
        input  out_valid,
        input  shift_amount,
        input  shift_type,
        input  rd2
    );
endinterface

// File: rtl/shift_operand_stage.sv
// shift_operand_stage: decodes operand2 into shifter operands.
// Registered, valid/ready, 2-entry skid, sync flush.
//
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : shift_operand_stage_if.slave (handshake and operands)
//
// Optional feature macro: SHIFT_CARRY_EN
//   defined   : shifter_carry output and carry_in input exist
//   undefined : no carry logic is built
//
// shift_type 2'b11 means pass rd2 through unshifted; every
// case the shifter cannot do is folded into that form here.
module shift_operand_stage #(
    parameter int DATA_W = 32
) (
    input logic                  clk,
    input logic                  rst,
    shift_operand_stage_if.slave bus
);

    localparam logic [1:0] T_LSL  = 2'b00;
    localparam logic [1:0] T_LSR  = 2'b01;
    localparam logic [1:0] T_ASR  = 2'b10;
    localparam logic [1:0] T_ROR  = 2'b11;
    localparam logic [1:0] T_PASS = 2'b11;

    typedef struct packed {
`ifdef SHIFT_CARRY_EN
        logic              c;
`endif
        logic [4:0]        amt;
        logic [1:0]        typ;
        logic [DATA_W-1:0] rd2;
    } beat_t;

    function automatic logic [DATA_W-1:0] ror(
        input logic [DATA_W-1:0] x,
        input logic [4:0]        n
    );
        logic [2*DATA_W-1:0] d;
        d = {x, x} >> n;
        return d[DATA_W-1:0];
    endfunction

    function automatic beat_t rst_beat();
        beat_t b;
        b     = '0;
        b.typ = T_PASS;
        return b;
    endfunction

    beat_t             r_main;
    beat_t             r_skid;
    logic              r_main_v;
    logic              r_skid_v;

    beat_t             w_dec;
    logic [7:0]        w_amt;
    logic              w_big;
    logic [DATA_W-1:0] w_imm_rot;
    logic [DATA_W-1:0] w_rm_rot;
    logic              w_accept;
    logic              w_consume;
    logic              w_in_ready;
    logic              w_unused;

    // Only the low byte of rs selects the amount.
    assign w_unused = ^bus.rs_data[DATA_W-1:8];

    // Effective amount; immediate #0 encodings remapped
    // (LSR/ASR #0 = #32, ROR #0 = ROR #1, LSL #0 = none).
    always_comb begin
        w_amt = 8'd0;
        if (bus.sh_reg) begin
            w_amt = bus.rs_data[7:0];
        end else if (bus.shamt_imm != 5'd0) begin
            w_amt = {3'b000, bus.shamt_imm};
        end else begin
            unique case (bus.sh_type_in)
                T_LSR, T_ASR: w_amt = 8'd32;
                T_ROR:        w_amt = 8'd1;
                default:      w_amt = 8'd0;
            endcase
        end
    end

    assign w_big     = |w_amt[7:5];
    assign w_rm_rot  = ror(bus.rm_data, w_amt[4:0]);
    assign w_imm_rot = ror({{(DATA_W-8){1'b0}}, bus.imm8},
                           {bus.rot4, 1'b0});

`ifdef SHIFT_CARRY_EN
    logic [4:0] w_lsl_idx;
    logic [4:0] w_lsr_idx;

    // Last bit out: LSL by n is rm[32-n], LSR/ASR is rm[n-1].
    assign w_lsl_idx = 5'd0 - w_amt[4:0];
    assign w_lsr_idx = w_amt[4:0] - 5'd1;
`endif

    always_comb begin
        w_dec     = '0;
        w_dec.typ = T_PASS;
        if (bus.op2_imm) begin
            w_dec.rd2 = w_imm_rot;
`ifdef SHIFT_CARRY_EN
            w_dec.c = (bus.rot4 != 4'd0) ? w_imm_rot[DATA_W-1]
                                         : bus.carry_in;
`endif
        end else if (w_amt == 8'd0) begin
            w_dec.rd2 = bus.rm_data;
`ifdef SHIFT_CARRY_EN
            w_dec.c = bus.carry_in;
`endif
        end else if (bus.sh_type_in == T_ROR) begin
            // Rotates are done here; the shifter never sees ROR.
            w_dec.rd2 = w_rm_rot;
`ifdef SHIFT_CARRY_EN
            w_dec.c = w_rm_rot[DATA_W-1];
`endif
        end else if (!w_big) begin
            w_dec.rd2 = bus.rm_data;
            w_dec.amt = w_amt[4:0];
            w_dec.typ = bus.sh_type_in;
`ifdef SHIFT_CARRY_EN
            if (bus.sh_type_in == T_LSL) begin
                w_dec.c = bus.rm_data[w_lsl_idx];
            end else begin
                w_dec.c = bus.rm_data[w_lsr_idx];
            end
`endif
        end else if (bus.sh_type_in == T_ASR) begin
            w_dec.rd2 = {DATA_W{bus.rm_data[DATA_W-1]}};
`ifdef SHIFT_CARRY_EN
            w_dec.c = bus.rm_data[DATA_W-1];
`endif
        end else begin
            w_dec.rd2 = '0;
`ifdef SHIFT_CARRY_EN
            if (w_amt != 8'd32) begin
                w_dec.c = 1'b0;
            end else if (bus.sh_type_in == T_LSL) begin
                w_dec.c = bus.rm_data[0];
            end else begin
                w_dec.c = bus.rm_data[DATA_W-1];
            end
`endif
        end
    end

    // in_ready is the skid register, never out_ready.
    assign w_in_ready = ~r_skid_v & ~rst;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_consume  = r_main_v & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main   <= rst_beat();
            r_skid   <= rst_beat();
        end else if (bus.flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (!r_main_v || w_consume) begin
            if (r_skid_v) begin
                r_main   <= r_skid;
                r_main_v <= 1'b1;
                r_skid_v <= 1'b0;
            end else if (w_accept) begin
                r_main   <= w_dec;
                r_main_v <= 1'b1;
            end else begin
                r_main_v <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid   <= w_dec;
            r_skid_v <= 1'b1;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_main_v;
    assign bus.shift_amount = r_main.amt;
    assign bus.shift_type   = r_main.typ;
    assign bus.rd2          = r_main.rd2;
`ifdef SHIFT_CARRY_EN
    assign bus.shifter_carry = r_main.c;
`endif

endmodule

// File: tb/tb_shift_operand_stage.sv
// tb_shift_operand_stage: directed vectors for the operand stage.
// Checks decode, backpressure, flush and async reset.
module tb_shift_operand_stage;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    shift_operand_stage_if #(.DATA_W(32)) u_if ();

    shift_operand_stage #(.DATA_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        imm;
        logic [7:0]  i8;
        logic [3:0]  r4;
        logic        sr;
        logic [4:0]  sh;
        logic [1:0]  ty;
        logic [31:0] rm;
        logic [31:0] rs;
        logic [31:0] e_rd2;
        logic [4:0]  e_amt;
        logic [1:0]  e_ty;
        logic        e_c;
    } vec_t;

    vec_t v[16];

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input vec_t x);
        u_if.op2_imm    = x.imm;
        u_if.imm8       = x.i8;
        u_if.rot4       = x.r4;
        u_if.sh_reg     = x.sr;
        u_if.shamt_imm  = x.sh;
        u_if.sh_type_in = x.ty;
        u_if.rm_data    = x.rm;
        u_if.rs_data    = x.rs;
    endtask

    task automatic check_out(input string tag, input vec_t x);
        check({tag, "_vld"}, 64'(u_if.out_valid), 64'd1);
        check({tag, "_rd2"}, 64'(u_if.rd2), 64'(x.e_rd2));
        check({tag, "_ty"}, 64'(u_if.shift_type), 64'(x.e_ty));
        check({tag, "_amt"}, 64'(u_if.shift_amount), 64'(x.e_amt));
`ifdef SHIFT_CARRY_EN
        check({tag, "_c"}, 64'(u_if.shifter_carry), 64'(x.e_c));
`endif
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_vld"}, 64'(u_if.out_valid), 64'd0);
        check({tag, "_ty"}, 64'(u_if.shift_type), 64'd3);
        check({tag, "_rd2"}, 64'(u_if.rd2), 64'd0);
        check({tag, "_amt"}, 64'(u_if.shift_amount), 64'd0);
        check({tag, "_rdy"}, 64'(u_if.in_ready), 64'd0);
    endtask

    initial begin
        //          imm i8     r4 sr sh  ty   rm            rs      rd2            amt ty c
        v[0]  = '{1, 8'hFF, 4, 0, 0,  0, 32'h0,        32'd0,  32'hFF000000, 0, 3, 1};
        v[1]  = '{1, 8'h3F, 0, 0, 0,  0, 32'h0,        32'd0,  32'h0000003F, 0, 3, 1};
        v[2]  = '{0, 8'h00, 0, 1, 0,  0, 32'h12345678, 32'd40, 32'h00000000, 0, 3, 0};
        v[3]  = '{0, 8'h00, 0, 1, 0,  2, 32'h80000000, 32'd33, 32'hFFFFFFFF, 0, 3, 1};
        v[4]  = '{0, 8'h00, 0, 0, 0,  1, 32'h80000000, 32'd0,  32'h00000000, 0, 3, 1};
        v[5]  = '{0, 8'h00, 0, 0, 4,  0, 32'h00000001, 32'd0,  32'h00000001, 4, 0, 0};
        v[6]  = '{0, 8'h00, 0, 1, 0,  3, 32'h000000AB, 32'd8,  32'hAB000000, 0, 3, 1};
        v[7]  = '{0, 8'h00, 0, 0, 0,  0, 32'hDEADBEEF, 32'd0,  32'hDEADBEEF, 0, 3, 1};
        v[8]  = '{0, 8'h00, 0, 0, 0,  2, 32'h40000000, 32'd0,  32'h00000000, 0, 3, 0};
        v[9]  = '{0, 8'h00, 0, 0, 0,  3, 32'h00000003, 32'd0,  32'h80000001, 0, 3, 1};
        v[10] = '{0, 8'h00, 0, 1, 0,  2, 32'h00000055, 32'd0,  32'h00000055, 0, 3, 1};
        v[11] = '{0, 8'h00, 0, 1, 0,  1, 32'h000000F0, 32'd5,  32'h000000F0, 5, 1, 1};
        v[12] = '{0, 8'h00, 0, 1, 0,  1, 32'h000000F0, 32'h105, 32'h000000F0, 5, 1, 1};
        v[13] = '{0, 8'h00, 0, 1, 0,  3, 32'h12345678, 32'd36, 32'h81234567, 0, 3, 1};
        v[14] = '{0, 8'h00, 0, 1, 0,  3, 32'h12345678, 32'd32, 32'h12345678, 0, 3, 0};
        v[15] = '{0, 8'h00, 0, 0, 31, 2, 32'h80000000, 32'd0,  32'h80000000, 31, 2, 0};

        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        u_if.flush     = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b0;
`ifdef SHIFT_CARRY_EN
        u_if.carry_in  = 1'b1;
`endif
        set_vec(v[0]);

        // Reset state
        tick();
        tick();
        check_reset("rst");
        #2 rst = 1'b0;
        #1 check("rst_rel_rdy", 64'(u_if.in_ready), 64'd1);

        // Decode table, one beat per cycle
        @(negedge clk);
        u_if.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_vec(v[i]);
            u_if.in_valid = 1'b1;
            tick();
            check_out($sformatf("v%0d", i), v[i]);
        end
        u_if.in_valid = 1'b0;
        tick();
        check("drain_vld", 64'(u_if.out_valid), 64'd0);

        // Backpressure: A, B held, C stalls upstream
        u_if.out_ready = 1'b0;
        set_vec(v[5]);
        u_if.in_valid = 1'b1;
        tick();
        check("bp_a_rdy", 64'(u_if.in_ready), 64'd1);
        check_out("bp_a", v[5]);
        set_vec(v[11]);
        tick();
        check("bp_b_rdy", 64'(u_if.in_ready), 64'd0);
        check_out("bp_a_hold", v[5]);
        set_vec(v[6]);
        tick();
        check("bp_c_rdy", 64'(u_if.in_ready), 64'd0);
        check_out("bp_a_hold2", v[5]);
        u_if.out_ready = 1'b1;
        tick();
        check_out("bp_b", v[11]);
        check("bp_b_rdy2", 64'(u_if.in_ready), 64'd1);
        tick();
        u_if.in_valid = 1'b0;
        check_out("bp_c", v[6]);
        tick();
        check("bp_end_vld", 64'(u_if.out_valid), 64'd0);

        // Flush with a simultaneous accept
        u_if.out_ready = 1'b0;
        set_vec(v[0]);
        u_if.in_valid = 1'b1;
        tick();
        set_vec(v[1]);
        tick();
        check("fl_full_rdy", 64'(u_if.in_ready), 64'd0);
        set_vec(v[2]);
        u_if.flush = 1'b1;
        tick();
        u_if.flush    = 1'b0;
        u_if.in_valid = 1'b0;
        check("fl_vld", 64'(u_if.out_valid), 64'd0);
        check("fl_rdy", 64'(u_if.in_ready), 64'd1);
        u_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("fl_none%0d", i),
                  64'(u_if.out_valid), 64'd0);
        end

        // Async reset while skid is full
        u_if.out_ready = 1'b0;
        set_vec(v[13]);
        u_if.in_valid = 1'b1;
        tick();
        tick();
        u_if.in_valid = 1'b0;
        check("mr_full_rdy", 64'(u_if.in_ready), 64'd0);
        #2 rst = 1'b1;
        #1 check_reset("mr");
        #2 rst = 1'b0;
        #1 check("mr_rel_rdy", 64'(u_if.in_ready), 64'd1);
        @(negedge clk);
        u_if.out_ready = 1'b1;
        set_vec(v[3]);
        u_if.in_valid = 1'b1;
        tick();
        u_if.in_valid = 1'b0;
        check_out("mr_after", v[3]);
        tick();
        check("mr_end_vld", 64'(u_if.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/shift_operand_stage.md
Name: shift_operand_stage

Overview:
- Pipeline stage directly upstream of the execute-stage shifter; produces its shift_amount, shift_type and rd2 operands.
- Decodes the data-processing operand2 field:
  - rotated 8-bit immediate
  - register shifted by a 5-bit immediate
  - register shifted by the low byte of a second register
- Folds every case the shifter cannot do into a pass-through operand (shift_type 2'b11 = no shift): rotates, amounts >=32, and the immediate LSR/ASR #0 encodings.
- Registered, valid/ready handshake, 2-entry skid buffer, synchronous flush.

Parameters:
- DATA_W, 32, operand width; only 32 is supported; width checks elsewhere assume it.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream operand beat valid
- in_ready  out  1  stage can accept a beat this cycle
- op2_imm  in  1  1 = rotated-immediate operand2
- imm8  in  8  immediate value
- rot4  in  4  immediate rotate; rotate right by 2*rot4
- sh_reg  in  1  1 = amount from rs_data[7:0]; 0 = from shamt_imm
- shamt_imm  in  5  immediate shift amount
- sh_type_in  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- rm_data  in  DATA_W  register operand to be shifted
- rs_data  in  DATA_W  shift-amount register, bits [7:0] used
- out_valid  out  1  outputs hold a valid beat
- out_ready  in  1  downstream consumes the beat
- shift_amount  out  5  to shifter
- shift_type  out  2  to shifter (11 = pass-through)
- rd2  out  DATA_W  to shifter

Behaviour:
Reset:
- Asynchronous on rst=1: out_valid=0, shift_amount=0, shift_type=2'b11, rd2=0, skid buffer empty.
- in_ready=0 while rst is high; in_ready=1 in the first cycle after rst falls.

Handshake:
- A beat is accepted when in_valid & in_ready; it is consumed when out_valid & out_ready.
- Latency: accept in cycle N gives out_valid in cycle N+1.
- in_ready = ~skid_valid, driven from a register with no combinational path from out_ready.
- Main register empty, or consumed this cycle: the accepted beat loads the main register.
- Main register full and not consumed: the accepted beat loads the skid register.
- Main register consumed while the skid is full: the skid moves to main, and the skid empties in the same edge.
- Output fields stay stable while out_valid & ~out_ready.
- Order is preserved; no beat is dropped or duplicated.

Flush:
- flush=1 clears main and skid valid at the next edge.
- A simultaneous accept is discarded; flush wins.
- Data registers may retain stale values; out_valid=0 afterwards.

Decode (amt = effective amount):
- op2_imm=1: rd2 = ror({24'b0,imm8}, 2*rot4), shift_type=11, shift_amount=0.
- sh_reg=0: amt = shamt_imm.
  - LSL #0: pass-through of rm_data.
  - LSR #0 means #32.
  - ASR #0 means #32.
  - ROR #0 is treated as ROR #1 without carry-in (RRX unsupported); rd2 = ror(rm,1).
- sh_reg=1: amt = rs_data[7:0].
  - amt=0: pass-through of rm_data, any type.
- 1<=amt<=31, types LSL/LSR/ASR: forward rm_data, amt[4:0], sh_type_in unchanged.
- amt>=32:
  - LSL/LSR: rd2=0, type 11.
  - ASR: rd2={DATA_W{rm_data[31]}}, type 11.
- ROR with amt>=1: rd2 = ror(rm_data, amt mod 32), type 11, computed in this stage.
- Whenever shift_type=11 is emitted, shift_amount=0.

Optional Feature:
- Macro SHIFT_CARRY_EN.
- Defined: adds output shifter_carry (1 bit), registered and travelling with the beat.
  - Value is the last bit shifted out per ARM rules.
  - LSL amt=32 gives rm[0]; LSL amt>32 gives 0.
  - LSR #32 gives rm[31].
  - ASR amt>=32 gives rm[31].
  - Immediate with rot4≠0 gives bit 31 of the result.
- Defined: new input carry_in (1 bit) supplies the carry for amt=0 and for immediates with rot4=0.
- Undefined: neither port exists and no carry logic is built.

Test Plan:
- Immediate: op2_imm=1, imm8=0xFF, rot4=4, out_ready=1 -> next cycle out_valid=1, rd2=0xFF000000, shift_type=11, shift_amount=0.
- Register amount saturation: sh_reg=1, rs_data=40, LSL, rm=0x12345678 -> rd2=0, type 11; repeat with ASR, rs=33, rm=0x80000000 -> rd2=0xFFFFFFFF.
- Immediate special cases:
  - LSR #0, rm=0x80000000 -> rd2=0, type 11.
  - LSL #4, rm=0x1 -> rd2=0x1, type 00, shift_amount=4.
  - ROR #8 via rs=8, rm=0x000000AB -> rd2=0xAB000000.
- Backpressure: out_ready=0, three consecutive in_valid beats A,B,C -> A,B accepted, in_ready=0 after B, C held upstream; raising out_ready yields A,B,C in order, one per cycle.
- Flush: two beats held, flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and no beat ever appears.
- Reset mid-operation: assert rst while skid is full -> out_valid=0, shift_type=11, rd2=0 immediately (asynchronous); after release in_ready=1 and the stage operates normally.
